// File: rtl/rf_pkg.sv
// ---------------------------------------------------------------------------
// rf_pkg : shared widths and types for the register file and its write port
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package rf_pkg;
  localparam int XLEN   = 32;
  localparam int REG_AW = 5;
  localparam int NREG   = 1 << REG_AW;

  typedef logic [REG_AW-1:0] regaddr_t;
  typedef logic [XLEN-1:0]   word_t;
endpackage

`default_nettype wire

// File: rtl/rr_arb2.sv
// ---------------------------------------------------------------------------
// rr_arb2 : two-requester round-robin arbiter, pointer moves on contention only
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module rr_arb2 (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  logic rr_ptr_q;
  logic rr_ptr_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) rr_ptr_q <= 1'b0;
    else          rr_ptr_q <= rr_ptr_d;
  end

  always_comb begin
    gnt      = 2'b00;
    rr_ptr_d = rr_ptr_q;
    case (req)
      2'b01: gnt = 2'b01;
      2'b10: gnt = 2'b10;
      2'b11: begin
        // Winner is the pointed-at requester; the loser becomes the favourite.
        gnt      = rr_ptr_q ? 2'b10 : 2'b01;
        rr_ptr_d = ~rr_ptr_q;
      end
      default: gnt = 2'b00;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/rf_wb_arbiter.sv
// ---------------------------------------------------------------------------
// rf_wb_arbiter : shares the register-file write port between the pipeline and
// the long-latency unit, and tracks pending long-latency destinations.
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module rf_wb_arbiter #(
  parameter int XLEN   = rf_pkg::XLEN,
  parameter int REG_AW = rf_pkg::REG_AW
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              wb0_valid,
  input  logic [REG_AW-1:0] wb0_rd,
  input  logic [XLEN-1:0]   wb0_data,
  output logic              wb0_ready,
  input  logic              wb1_valid,
  input  logic [REG_AW-1:0] wb1_rd,
  input  logic [XLEN-1:0]   wb1_data,
  output logic              wb1_ready,
  input  logic              alloc_valid,
  input  logic [REG_AW-1:0] alloc_rd,
  output logic              alloc_ready,
  input  logic [REG_AW-1:0] chk_ra1,
  input  logic [REG_AW-1:0] chk_ra2,
  input  logic [REG_AW-1:0] chk_rd,
  output logic              busy_ra1,
  output logic              busy_ra2,
  output logic              busy_rd,
  output logic              we3,
  output logic [REG_AW-1:0] wa3,
  output logic [XLEN-1:0]   wd3,
  output logic              idle
);

  localparam int NREG = 1 << REG_AW;

  logic [1:0]      req;
  logic [1:0]      gnt;
  logic [NREG-1:0] busy_q;
  logic [NREG-1:0] busy_d;
  logic            wb1_xfer;
  logic            alloc_xfer;

  // Requests are masked while reset is held so every ready reads low.
  assign req = {wb1_valid, wb0_valid} & {2{reset_n}};

  rr_arb2 u_arb (
    .clk     (clk),
    .reset_n (reset_n),
    .req     (req),
    .gnt     (gnt)
  );

  assign wb0_ready = gnt[0];
  assign wb1_ready = gnt[1];
  assign wb1_xfer  = gnt[1];

  always_comb begin
    wa3 = '0;
    wd3 = '0;
    if (gnt[0]) begin
      wa3 = wb0_rd;
      wd3 = wb0_data;
    end else if (gnt[1]) begin
      wa3 = wb1_rd;
      wd3 = wb1_data;
    end
  end

  assign we3 = (|gnt) && (wa3 != '0);

  // A result landing on the same register this cycle frees the slot for reuse.
  assign alloc_ready = reset_n &&
                       (!busy_q[alloc_rd] || (wb1_xfer && (wb1_rd == alloc_rd)));
  assign alloc_xfer  = alloc_valid && alloc_ready;

  always_comb begin
    busy_d = busy_q;
    if (wb1_xfer) busy_d[wb1_rd] = 1'b0;
    if (alloc_xfer && (alloc_rd != '0)) busy_d[alloc_rd] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) busy_q <= '0;
    else          busy_q <= busy_d;
  end

  assign busy_ra1 = busy_q[chk_ra1];
  assign busy_ra2 = busy_q[chk_ra2];
  assign busy_rd  = busy_q[chk_rd];

  assign idle = !reset_n || ((busy_q == '0) && !wb0_valid && !wb1_valid);

endmodule

`default_nettype wire

// File: tb/tb_rf_wb_arbiter.sv
// ---------------------------------------------------------------------------
// tb_rf_wb_arbiter : directed bench for rf_wb_arbiter with a register-file model
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_rf_wb_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        wb0_valid, wb1_valid, alloc_valid;
  logic [4:0]  wb0_rd, wb1_rd, alloc_rd;
  logic [31:0] wb0_data, wb1_data;
  logic        wb0_ready, wb1_ready, alloc_ready;
  logic [4:0]  chk_ra1, chk_ra2, chk_rd;
  logic        busy_ra1, busy_ra2, busy_rd;
  logic        we3;
  logic [4:0]  wa3;
  logic [31:0] wd3;
  logic        idle;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] rf [32];

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (we3 && wa3 != 5'd0) rf[wa3] <= wd3;
  end

  rf_wb_arbiter dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .wb0_valid   (wb0_valid),
    .wb0_rd      (wb0_rd),
    .wb0_data    (wb0_data),
    .wb0_ready   (wb0_ready),
    .wb1_valid   (wb1_valid),
    .wb1_rd      (wb1_rd),
    .wb1_data    (wb1_data),
    .wb1_ready   (wb1_ready),
    .alloc_valid (alloc_valid),
    .alloc_rd    (alloc_rd),
    .alloc_ready (alloc_ready),
    .chk_ra1     (chk_ra1),
    .chk_ra2     (chk_ra2),
    .chk_rd      (chk_rd),
    .busy_ra1    (busy_ra1),
    .busy_ra2    (busy_ra2),
    .busy_rd     (busy_rd),
    .we3         (we3),
    .wa3         (wa3),
    .wd3         (wd3),
    .idle        (idle)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge, then settle away from it.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk_reset_outputs(input string pfx);
    chk({pfx, "_wb0_ready"},   {31'd0, wb0_ready},   32'd0);
    chk({pfx, "_wb1_ready"},   {31'd0, wb1_ready},   32'd0);
    chk({pfx, "_alloc_ready"}, {31'd0, alloc_ready}, 32'd0);
    chk({pfx, "_we3"},         {31'd0, we3},         32'd0);
    chk({pfx, "_wa3"},         {27'd0, wa3},         32'd0);
    chk({pfx, "_wd3"},         wd3,                  32'd0);
    chk({pfx, "_busy_ra1"},    {31'd0, busy_ra1},    32'd0);
    chk({pfx, "_idle"},        {31'd0, idle},        32'd1);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) rf[i] = 32'd0;
    reset_n = 1'b0;
    wb0_valid = 1'b1; wb0_rd = 5'd3; wb0_data = 32'h1111_1111;
    wb1_valid = 1'b1; wb1_rd = 5'd4; wb1_data = 32'h2222_2222;
    alloc_valid = 1'b1; alloc_rd = 5'd7;
    chk_ra1 = 5'd7; chk_ra2 = 5'd0; chk_rd = 5'd0;
    #2;
    chk_reset_outputs("por");

    // Leave reset with nothing requesting.
    wb0_valid = 1'b0; wb1_valid = 1'b0; alloc_valid = 1'b0;
    tick();
    reset_n = 1'b1;
    #1;
    chk("post_reset_idle", {31'd0, idle}, 32'd1);

    // Lone pipeline writeback.
    wb0_valid = 1'b1; wb0_rd = 5'd5; wb0_data = 32'hDEAD_BEEF;
    #1;
    chk("wb0_only_ready", {31'd0, wb0_ready}, 32'd1);
    chk("wb0_only_we3",   {31'd0, we3},       32'd1);
    chk("wb0_only_wa3",   {27'd0, wa3},       32'd5);
    chk("wb0_only_wd3",   wd3,                32'hDEAD_BEEF);
    tick();
    wb0_valid = 1'b0;
    #1;
    chk("rf5_readback", rf[5], 32'hDEAD_BEEF);
    chk("nogrant_we3",  {31'd0, we3}, 32'd0);
    chk("nogrant_wa3",  {27'd0, wa3}, 32'd0);
    chk("nogrant_wd3",  wd3,          32'd0);

    // Contention: expect wb0, wb1, wb0, wb1.
    wb0_valid = 1'b1; wb0_rd = 5'd1; wb0_data = 32'hA000_0001;
    wb1_valid = 1'b1; wb1_rd = 5'd2; wb1_data = 32'hB000_0001;
    #1;
    chk("rr1_wb0_ready", {31'd0, wb0_ready}, 32'd1);
    chk("rr1_wb1_ready", {31'd0, wb1_ready}, 32'd0);
    chk("rr1_wa3",       {27'd0, wa3},       32'd1);
    chk("rr1_wd3",       wd3,                32'hA000_0001);
    tick();
    wb0_rd = 5'd3; wb0_data = 32'hA000_0002;
    #1;
    chk("rr2_wb0_ready", {31'd0, wb0_ready}, 32'd0);
    chk("rr2_wb1_ready", {31'd0, wb1_ready}, 32'd1);
    chk("rr2_wa3",       {27'd0, wa3},       32'd2);
    chk("rr2_wd3",       wd3,                32'hB000_0001);
    tick();
    wb1_rd = 5'd4; wb1_data = 32'hB000_0002;
    #1;
    chk("rr3_wb0_ready", {31'd0, wb0_ready}, 32'd1);
    chk("rr3_wb1_ready", {31'd0, wb1_ready}, 32'd0);
    chk("rr3_wd3",       wd3,                32'hA000_0002);
    tick();
    wb0_rd = 5'd6; wb0_data = 32'hA000_0003;
    #1;
    chk("rr4_wb0_ready", {31'd0, wb0_ready}, 32'd0);
    chk("rr4_wb1_ready", {31'd0, wb1_ready}, 32'd1);
    chk("rr4_wd3",       wd3,                32'hB000_0002);
    tick();
    wb0_valid = 1'b0; wb1_valid = 1'b0;
    #1;
    chk("rf1_after_rr", rf[1], 32'hA000_0001);
    chk("rf2_after_rr", rf[2], 32'hB000_0001);
    chk("rf3_after_rr", rf[3], 32'hA000_0002);
    chk("rf4_after_rr", rf[4], 32'hB000_0002);

    // Allocate r7, re-allocate refused, release by wb1.
    alloc_valid = 1'b1; alloc_rd = 5'd7; chk_ra1 = 5'd7; chk_rd = 5'd7;
    #1;
    chk("alloc7_ready",    {31'd0, alloc_ready}, 32'd1);
    chk("alloc7_busy_pre", {31'd0, busy_ra1},    32'd0);
    tick();
    chk("alloc7_busy_ra1", {31'd0, busy_ra1},    32'd1);
    chk("alloc7_busy_rd",  {31'd0, busy_rd},     32'd1);
    chk("alloc7_idle",     {31'd0, idle},        32'd0);
    chk("alloc7_again",    {31'd0, alloc_ready}, 32'd0);
    tick();
    alloc_valid = 1'b0;
    wb1_valid = 1'b1; wb1_rd = 5'd7; wb1_data = 32'h0000_0077;
    #1;
    chk("wb1_r7_ready",    {31'd0, wb1_ready}, 32'd1);
    chk("wb1_r7_busy_now", {31'd0, busy_ra1},  32'd1);
    tick();
    wb1_valid = 1'b0;
    #1;
    chk("wb1_r7_cleared", {31'd0, busy_ra1}, 32'd0);
    chk("rf7_written",    rf[7],             32'h0000_0077);

    // Same-cycle release and re-allocate of r9: set wins.
    alloc_valid = 1'b1; alloc_rd = 5'd9; chk_ra2 = 5'd9;
    tick();
    chk("alloc9_busy", {31'd0, busy_ra2}, 32'd1);
    wb1_valid = 1'b1; wb1_rd = 5'd9; wb1_data = 32'h9999_0009;
    #1;
    chk("r9_alloc_ready", {31'd0, alloc_ready}, 32'd1);
    chk("r9_wb1_ready",   {31'd0, wb1_ready},   32'd1);
    chk("r9_we3",         {31'd0, we3},         32'd1);
    chk("r9_wa3",         {27'd0, wa3},         32'd9);
    tick();
    alloc_valid = 1'b0;
    wb1_data = 32'h9999_000A;
    #1;
    chk("r9_still_busy", {31'd0, busy_ra2}, 32'd1);
    chk("rf9_written",   rf[9],             32'h9999_0009);
    tick();
    wb1_valid = 1'b0;
    #1;
    chk("r9_cleared", {31'd0, busy_ra2}, 32'd0);
    chk("r9_idle",    {31'd0, idle},     32'd1);

    // Register zero: handshakes complete, nothing written or tracked.
    wb0_valid = 1'b1; wb0_rd = 5'd0; wb0_data = 32'hCAFE_0000;
    wb1_valid = 1'b1; wb1_rd = 5'd0; wb1_data = 32'hCAFE_0001;
    alloc_valid = 1'b1; alloc_rd = 5'd0; chk_rd = 5'd0;
    #1;
    chk("x0_wb0_ready",   {31'd0, wb0_ready},   32'd1);
    chk("x0_wb0_we3",     {31'd0, we3},         32'd0);
    chk("x0_alloc_ready", {31'd0, alloc_ready}, 32'd1);
    tick();
    wb0_valid = 1'b0; alloc_valid = 1'b0;
    #1;
    chk("x0_wb1_ready", {31'd0, wb1_ready}, 32'd1);
    chk("x0_wb1_we3",   {31'd0, we3},       32'd0);
    chk("x0_busy_rd",   {31'd0, busy_rd},   32'd0);
    tick();
    wb1_valid = 1'b0;
    #1;
    chk("x0_idle", {31'd0, idle}, 32'd1);

    // Reset in the middle of traffic with r7 pending.
    alloc_valid = 1'b1; alloc_rd = 5'd7; chk_ra1 = 5'd7;
    tick();
    chk("pre_rst_busy7", {31'd0, busy_ra1}, 32'd1);
    wb0_valid = 1'b1; wb0_rd = 5'd12; wb0_data = 32'h1234_5678;
    wb1_valid = 1'b1; wb1_rd = 5'd7;  wb1_data = 32'h8765_4321;
    #1;
    reset_n = 1'b0;
    #1;
    chk_reset_outputs("mid");
    tick();
    alloc_valid = 1'b0; wb0_valid = 1'b0;
    reset_n = 1'b1;
    #1;
    chk("late_wb1_ready", {31'd0, wb1_ready}, 32'd1);
    chk("late_wb1_we3",   {31'd0, we3},       32'd1);
    chk("late_busy7",     {31'd0, busy_ra1},  32'd0);
    tick();
    wb1_valid = 1'b0;
    #1;
    chk("late_rf7",   rf[7],          32'h8765_4321);
    chk("late_idle",  {31'd0, idle},  32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/rf_wb_arbiter.md
# rf_wb_arbiter

Write-port arbiter and pending-write scoreboard for the 32×32 three-port register file (2 combinational read ports, 1 write port on rising edge, x0 hardwired to zero). Shares the single write port between the in-order pipeline writeback (requester 0) and the long-latency unit writeback (requester 1, mul/div/load). Tracks which registers have an outstanding long-latency result so the issue stage can stall on RAW and WAW hazards. Sits between the writeback stage, the long-latency unit and the register file.

## Interface
Parameters:
- XLEN, 32, data width
- REG_AW, 5, register address width (32 registers)

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset_n  in  1  asynchronous, active-low reset
- wb0_valid, wb0_rd, wb0_data  in  1/REG_AW/XLEN  pipeline writeback request
- wb0_ready  out  1  pipeline request granted this cycle
- wb1_valid, wb1_rd, wb1_data  in  1/REG_AW/XLEN  long-latency writeback request
- wb1_ready  out  1  long-latency request granted this cycle
- alloc_valid, alloc_rd  in  1/REG_AW  issue of a long-latency op targeting alloc_rd
- alloc_ready  out  1  allocation accepted
- chk_ra1, chk_ra2, chk_rd  in  REG_AW  issue-stage lookup addresses
- busy_ra1, busy_ra2, busy_rd  out  1  scoreboard bit for each lookup address
- we3, wa3, wd3  out  1/REG_AW/XLEN  register-file write port
- idle  out  1  no busy register and no valid request

## Operation
- A transfer occurs when valid && ready are both high at a rising edge. ready depends combinationally on valid and state. A requester must hold valid, rd and data until it transfers.
- Arbitration: a lone valid requester is granted. If both are valid, grant the requester selected by rr_ptr. rr_ptr then points at the loser. rr_ptr changes only on contested cycles.
- The granted requester drives wa3/wd3. we3 = granted && (rd != 0).
- A write to rd = 0 completes the handshake with we3 = 0.
- When no grant: we3 = 0 and wa3/wd3 = 0.
- Scoreboard busy[31:1]. busy[0] reads as 0 at all times.
- Set: alloc transfer with alloc_rd != 0 sets busy[alloc_rd].
- Clear: wb1 transfer clears busy[wb1_rd]. A wb0 transfer never clears a busy bit.
- alloc_ready = !busy[alloc_rd] || (wb1 transfer this cycle to the same rd). If set and clear hit the same register in one cycle, set wins.
- A wb1 write to a non-busy register is legal: it is written and busy is unchanged.
- A wb0 write to a busy register is a protocol violation. The issue stage prevents it by checking busy_rd.
- idle = (busy == 0) && !wb0_valid && !wb1_valid.

## Timing
- Reset (async assert, deassertion synchronous to clk): busy = 0, rr_ptr = 0 (wb0 favoured first).
- During reset: we3 = 0, wa3 = 0, wd3 = 0, wb0_ready = 0, wb1_ready = 0, alloc_ready = 0, busy_* = 0, idle = 1.
- Write latency is zero: the register file captures wd3 at the same edge as the handshake, and the value is readable in the next cycle.
- Scoreboard updates are visible on busy_* one cycle after the alloc or wb1 edge.
- Reset mid-operation drops all busy bits. Long-latency results arriving afterwards are written normally.
- No combinational path from wd3 to any ready signal.

## Structure
- Shared package rf_pkg holds:
  - XLEN and REG_AW
  - typedef logic [REG_AW-1:0] regaddr_t
  - typedef logic [XLEN-1:0] word_t
  - localparam NREG = 1 << REG_AW
- Sub-module rr_arb2: 2-input round-robin arbiter holding rr_ptr. Inputs: clk, reset_n, req[1:0]. Output: gnt[1:0], one-hot or zero.
- Scoreboard, muxing and lookup logic stay in the top module.

## Test plan
- Reset: assert reset_n = 0 mid-traffic with busy[7] set → all outputs at the reset values above; busy_ra1 = 0 for chk_ra1 = 7; idle = 1.
- wb0 only, rd = 5, data 0xDEADBEEF → wb0_ready = 1, we3 = 1, wa3 = 5, wd3 = 0xDEADBEEF; register-file rd1 = 0xDEADBEEF next cycle with ra1 = 5.
- Both valid for 4 cycles with fresh data each transfer → grant order wb0, wb1, wb0, wb1. Each loser's ready stays 0 until its turn.
- alloc rd = 7:
  - → busy_ra1 = 1 the next cycle with chk_ra1 = 7.
  - Second alloc rd = 7 → alloc_ready = 0.
  - wb1 rd = 7 → busy clears the cycle after.
- Same-cycle wb1 rd = 9 and alloc rd = 9 while busy[9] = 1 → alloc_ready = 1, write occurs, busy[9] stays 1.
- wb0 and wb1 with rd = 0, plus alloc rd = 0 → handshakes complete, we3 = 0, no busy bit set, idle returns to 1.
